// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the command sequencer.
package cmd_seq_pkg;
  typedef enum logic [2:0] {IDLE, CAL, HEAD, MOVE, RESP} state_t;

  localparam logic [3:0] OP_CAL     = 4'h0;
  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_MOVE_FF = 4'h3;

  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'h5A;
endpackage

// File: rtl/line_cntr.sv
// Rising-edge detector on the line sensor feeding a clearable 5-bit counter.
module line_cntr (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       line_in,
  output logic [4:0] cnt
);
  logic       line_q;
  logic [4:0] cnt_q;
  logic       rise;

  // The previous sample tracks continuously so entering MOVE with the line
  // already high does not register a false edge.
  assign rise = line_in & ~line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_in;
      if (clr)            cnt_q <= '0;
      else if (en && rise) cnt_q <= cnt_q + 5'd1;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: decodes UART commands into calibration or line-counted
// moves and returns an ACK/NACK byte once the action completes.
module cmd_sequencer
  import cmd_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_rdy,
  input  logic [15:0] cmd,
  output logic        clr_cmd_rdy,
  output logic        cal_go,
  input  logic        cal_done,
  output logic        mv_go,
  output logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        line_in,
  output logic        fanfare_go,
  output logic        trmt,
  output logic [7:0]  resp,
  input  logic        tx_done
);
  state_t      state_q, state_d;
  logic [11:0] heading_q, heading_d;
  logic [3:0]  squares_q, squares_d;
  logic        ff_q, ff_d;
  logic [7:0]  resp_q, resp_d;
  logic        trmt_q, trmt_d;
  logic        cnt_clr;
  logic [4:0]  cnt;
  logic [3:0]  opcode;

  assign opcode = cmd[15:12];

  line_cntr u_line_cntr (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == MOVE),
    .clr     (cnt_clr),
    .line_in (line_in),
    .cnt     (cnt)
  );

  always_comb begin
    state_d     = state_q;
    heading_d   = heading_q;
    squares_d   = squares_q;
    ff_d        = ff_q;
    resp_d      = resp_q;
    clr_cmd_rdy = 1'b0;
    cal_go      = 1'b0;
    fanfare_go  = 1'b0;
    cnt_clr     = 1'b0;
    case (state_q)
      IDLE: if (cmd_rdy) begin
        clr_cmd_rdy = 1'b1;
        heading_d   = {cmd[11:4], 4'h0};
        squares_d   = cmd[3:0];
        ff_d        = (opcode == OP_MOVE_FF);
        case (opcode)
          OP_CAL: begin
            cal_go  = 1'b1;
            state_d = CAL;
          end
          OP_MOVE, OP_MOVE_FF: state_d = HEAD;
          default: begin
            resp_d  = NACK;
            state_d = RESP;
          end
        endcase
      end
      CAL: if (cal_done) begin
        resp_d  = ACK;
        state_d = RESP;
      end
      HEAD: if (heading_rdy) begin
        if (squares_q == 4'd0) begin
          resp_d  = ACK;
          state_d = RESP;
        end else begin
          cnt_clr = 1'b1;
          state_d = MOVE;
        end
      end
      // Completion looks only at the count, so heading_rdy dropping here is moot.
      MOVE: if (cnt == {squares_q, 1'b0}) begin
        fanfare_go = ff_q;
        resp_d     = ACK;
        state_d    = RESP;
      end
      RESP: if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // trmt is registered so it lands on the first RESP cycle alongside resp.
  assign trmt_d = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      heading_q <= '0;
      squares_q <= '0;
      ff_q      <= 1'b0;
      resp_q    <= '0;
      trmt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      squares_q <= squares_d;
      ff_q      <= ff_d;
      resp_q    <= resp_d;
      trmt_q    <= trmt_d;
    end
  end

  assign mv_go   = (state_q == HEAD) || (state_q == MOVE);
  assign heading = heading_q;
  assign resp    = resp_q;
  assign trmt    = trmt_q;
endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: table of commands plus hand-written
// corner sequences; response bytes are checked through a scoreboard queue.
module tb_cmd_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_rdy = 1'b0, cal_done = 1'b0, heading_rdy = 1'b0;
  logic        line_in = 1'b0, tx_done = 1'b0;
  logic [15:0] cmd = '0;
  logic        clr_cmd_rdy, cal_go, mv_go, fanfare_go, trmt;
  logic [11:0] heading;
  logic [7:0]  resp;

  cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd),
    .clr_cmd_rdy(clr_cmd_rdy), .cal_go(cal_go), .cal_done(cal_done),
    .mv_go(mv_go), .heading(heading), .heading_rdy(heading_rdy),
    .line_in(line_in), .fanfare_go(fanfare_go), .trmt(trmt),
    .resp(resp), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  localparam int K_NONE = 0, K_CAL = 1, K_MV = 2;

  typedef struct {
    logic [15:0] cmd;
    int          kind;
    int          sq;
    logic [11:0] head;
    logic [7:0]  resp;
    int          ff;
  } vec_t;

  vec_t       tbl[7];
  logic [7:0] sb_q[$];
  int         n_cmp = 0, n_err = 0;
  int         trmt_cnt = 0, ff_cnt = 0, cal_cnt = 0, clr_cnt = 0;
  bit         mv_seen = 0;
  bit         hold_act = 0;
  logic [7:0] hold_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pulse counters, scoreboard pop on trmt, resp stability.
  always @(negedge clk) begin
    if (rst) hold_act = 0;
    else begin
      if (trmt) begin
        trmt_cnt++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_trmt: got resp %0h, required no trmt", resp);
        end else chk("resp_sb", resp, sb_q.pop_front());
        hold_val = resp;
        hold_act = 1;
      end else if (hold_act) begin
        chk("resp_hold", resp, hold_val);
        if (tx_done) hold_act = 0;
      end
      if (fanfare_go)  ff_cnt++;
      if (cal_go)      cal_cnt++;
      if (clr_cmd_rdy) clr_cnt++;
      if (mv_go)       mv_seen = 1;
    end
  end

  task automatic wait_trmt(input int t0);
    for (int i = 0; i < 300 && trmt_cnt == t0; i++) tick();
    chk("trmt_seen", trmt_cnt, t0 + 1);
  endtask

  task automatic line_edges(input int n);
    for (int e = 0; e < n; e++) begin
      line_in = 1'b1; tick(); tick();
      line_in = 1'b0; tick(); tick();
    end
  endtask

  task automatic do_cmd(input vec_t v);
    int t0;
    t0 = trmt_cnt;
    ff_cnt = 0; cal_cnt = 0; clr_cnt = 0; mv_seen = 0;
    sb_q.push_back(v.resp);
    tick();
    cmd = v.cmd; cmd_rdy = 1'b1;
    #1 chk("clr_latency", clr_cmd_rdy, 1);
    tick();
    cmd_rdy = 1'b0;
    chk("heading", heading, v.head);
    if (v.kind == K_CAL) begin
      repeat (100) tick();
      cal_done = 1'b1; tick(); cal_done = 1'b0;
    end else if (v.kind == K_MV) begin
      chk("mv_go_head", mv_go, 1);
      repeat (3) tick();
      heading_rdy = 1'b1; tick(); heading_rdy = 1'b0;
      line_edges(2 * v.sq);
    end
    wait_trmt(t0);
    chk("mv_go_resp", mv_go, 0);
    repeat (3) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    tick();
    chk("clr_count", clr_cnt, 1);
    chk("cal_count", cal_cnt, (v.kind == K_CAL) ? 1 : 0);
    chk("ff_count", ff_cnt, v.ff);
    chk("mv_seen", mv_seen, (v.kind == K_MV) ? 1 : 0);
  endtask

  initial begin
    int t0;
    tbl[0] = '{16'h0000, K_CAL,  0, 12'h000, 8'hA5, 0};
    tbl[1] = '{16'h23F2, K_MV,   2, 12'h3F0, 8'hA5, 0};
    tbl[2] = '{16'h3001, K_MV,   1, 12'h000, 8'hA5, 1};
    tbl[3] = '{16'h7123, K_NONE, 0, 12'h120, 8'h5A, 0};
    tbl[4] = '{16'h2A50, K_MV,   0, 12'hA50, 8'hA5, 0};
    tbl[5] = '{16'h1FFF, K_NONE, 0, 12'hFF0, 8'h5A, 0};
    tbl[6] = '{16'h3C83, K_MV,   3, 12'hC80, 8'hA5, 1};

    // Reset state
    repeat (3) tick();
    chk("rst_mv_go", mv_go, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_heading", heading, 0);
    chk("rst_resp", resp, 0);
    chk("rst_fanfare", fanfare_go, 0);
    chk("rst_cal_go", cal_go, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) do_cmd(tbl[i]);

    // cmd_rdy held through a move; stray cal_done in HEAD ignored
    t0 = trmt_cnt;
    sb_q.push_back(8'hA5);
    tick();
    cmd = 16'h2001; cmd_rdy = 1'b1;
    tick();
    cmd = 16'h7000;
    clr_cnt = 0;
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    chk("cal_done_ignored_mv", mv_go, 1);
    chk("cal_done_ignored_trmt", trmt_cnt, t0);
    heading_rdy = 1'b1; tick(); heading_rdy = 1'b0;
    line_edges(2);
    wait_trmt(t0);
    chk("held_no_clr", clr_cnt, 0);
    sb_q.push_back(8'h5A);
    repeat (2) tick();
    chk("held_no_clr_resp", clr_cnt, 0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    #1 chk("held_clr_first_idle", clr_cmd_rdy, 1);
    tick();
    cmd_rdy = 1'b0;
    wait_trmt(t0 + 1);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    tick();
    chk("held_clr_count", clr_cnt, 1);

    // Reset mid-MOVE after 1 of 4 edges
    t0 = trmt_cnt;
    tick();
    cmd = 16'h2552; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    heading_rdy = 1'b1; tick(); heading_rdy = 1'b0;
    line_edges(1);
    #2 rst = 1'b1;
    #1;
    chk("abort_mv_go", mv_go, 0);
    chk("abort_heading", heading, 0);
    chk("abort_resp", resp, 0);
    chk("abort_trmt", trmt, 0);
    tick();
    rst = 1'b0;
    repeat (30) tick();
    chk("abort_no_trmt", trmt_cnt, t0);

    do_cmd(tbl[3]);
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port cmd_rdy, input, 1, 16-bit command valid from the UART wrapper.
REQ-004 SHALL have port cmd, input, 16, command word: [15:12] opcode, [11:4] heading, [3:0] squares.
REQ-005 SHALL have port clr_cmd_rdy, output, 1, one-cycle pulse consuming the current cmd.
REQ-006 SHALL have port cal_go, output, 1, one-cycle pulse starting gyro calibration.
REQ-007 SHALL have port cal_done, input, 1, calibration complete (pulse or level).
REQ-008 SHALL have port mv_go, output, 1, level; high while motion is commanded.
REQ-009 SHALL have port heading, output, 12, desired heading = {cmd[11:4], 4'h0}, registered.
REQ-010 SHALL have port heading_rdy, input, 1, heading settled within tolerance.
REQ-011 SHALL have port line_in, input, 1, IR line sensor (already synchronised).
REQ-012 SHALL have port fanfare_go, output, 1, one-cycle pulse at end of a fanfare move.
REQ-013 SHALL have port trmt, output, 1, one-cycle pulse requesting transmission of resp.
REQ-014 SHALL have port resp, output, 8, response byte to the UART wrapper.
REQ-015 SHALL have port tx_done, input, 1, response byte transmitted.

Function
REQ-016 SHALL implement states IDLE, CAL, HEAD, MOVE, RESP.
REQ-017 IDLE: on cmd_rdy, SHALL pulse clr_cmd_rdy, latch heading and squares, and decode opcode in the same cycle.
REQ-018 Opcode 4'h0 (CAL): SHALL pulse cal_go and go to CAL; on cal_done go to RESP with resp=8'hA5.
REQ-019 Opcode 4'h2 (MOVE) and 4'h3 (MOVE_FF): SHALL go to HEAD with mv_go=1.
REQ-020 Any other opcode: SHALL go to RESP with resp=8'h5A; no motion, no cal_go.
REQ-021 HEAD: SHALL hold mv_go=1 until heading_rdy, then go to MOVE and clear the line counter.
REQ-022 If squares==0, HEAD SHALL go directly to RESP on heading_rdy with resp=8'hA5.
REQ-023 MOVE: SHALL count line_in rising edges; done when count == 2*squares (5-bit counter, no wrap for squares<=15).
REQ-024 On MOVE done, SHALL drop mv_go the next cycle and go to RESP with resp=8'hA5; for MOVE_FF, SHALL also pulse fanfare_go once.
REQ-025 RESP: on entry, SHALL pulse trmt once; SHALL stay until tx_done, then go to IDLE.
REQ-026 resp SHALL be held stable from the trmt pulse until tx_done.
REQ-027 cmd_rdy arriving outside IDLE SHALL be ignored; clr_cmd_rdy SHALL NOT be pulsed; the cmd is accepted on the first IDLE cycle it is still high.
REQ-028 line_in edges outside MOVE SHALL NOT change the counter.
REQ-029 cal_done outside CAL and heading_rdy outside HEAD SHALL be ignored.
REQ-030 Simultaneous edge-completes-count and heading_rdy drop in MOVE: completion SHALL take priority.
REQ-031 Latency: clr_cmd_rdy SHALL fire in the cycle cmd_rdy is sampled high in IDLE; trmt SHALL fire on the first RESP cycle.

Reset
REQ-032 On rst, SHALL enter IDLE with counter=0, heading=0, resp=8'h00, and all pulse outputs and mv_go low.
REQ-033 rst mid-operation SHALL abort immediately; no trmt for the aborted command.

Structure
REQ-034 Package cmd_seq_pkg SHALL hold the state enum, opcode constants (CAL=4'h0, MOVE=4'h2, MOVE_FF=4'h3), ACK=8'hA5, and NACK=8'h5A.
REQ-035 Sub-module line_cntr (edge detect plus clearable 5-bit counter) SHALL be instantiated once.

Verification
REQ-036 cmd=16'h0000 -> cal_go pulse; cal_done after 100 clk -> trmt with resp=A5; tx_done -> IDLE.
REQ-037 cmd=16'h23F2 -> heading=12'h3F0, mv_go=1; heading_rdy then 4 line_in rising edges -> mv_go=0, resp=A5, no fanfare_go.
REQ-038 cmd=16'h3001 -> after 2 edges -> fanfare_go exactly one pulse, then trmt with resp=A5.
REQ-039 cmd=16'h7123 -> resp=5A, trmt pulse, mv_go and cal_go never asserted.
REQ-040 cmd_rdy held during MOVE -> no clr_cmd_rdy until after tx_done; accepted on the first IDLE cycle.
REQ-041 rst asserted after 1 of 4 edges in MOVE -> all outputs reset immediately, no trmt.
